// File: rtl/load_store_queue.sv
// In-order load/store queue. Entries hold operands with busy/tag state and snoop the
// CDB channels. The head issues one memory operation at a time. Non-IO loads issue
// speculatively; IO loads wait until they are the oldest ROB entry, and stores wait
// until they are committed. A flush keeps the committed store prefix at the head.
module load_store_queue #(
    parameter int                DEPTH     = 8,
    parameter int                ROB_IDX_W = 4,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                NUM_CDB   = 2,
    parameter logic [ADDR_W-1:0] IO_BASE   = 'h0003_0000
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          rdy_in,
    input  logic                          clr_in,
    input  logic                          issue_valid,
    input  logic [ROB_IDX_W-1:0]          issue_rob_idx,
    input  logic                          issue_is_store,
    input  logic [1:0]                    issue_len,
    input  logic                          issue_unsigned,
    input  logic                          issue_rs1_busy,
    input  logic [ROB_IDX_W-1:0]          issue_rs1_tag,
    input  logic [DATA_W-1:0]             issue_rs1_val,
    input  logic                          issue_rs2_busy,
    input  logic [ROB_IDX_W-1:0]          issue_rs2_tag,
    input  logic [DATA_W-1:0]             issue_rs2_val,
    input  logic [DATA_W-1:0]             issue_imm,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_data,
    input  logic                          rob_commit_valid,
    input  logic [ROB_IDX_W-1:0]          rob_commit_idx,
    input  logic [ROB_IDX_W-1:0]          rob_head_idx,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [1:0]                    mem_len,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          lsq_full,
    output logic [$clog2(DEPTH):0]        lsq_count,
    output logic                          result_valid,
    output logic [ROB_IDX_W-1:0]          result_rob_idx,
    output logic [DATA_W-1:0]             result_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 is_store;
        logic [1:0]           len;
        logic                 is_unsigned;
        logic                 rs1_busy;
        logic [ROB_IDX_W-1:0] rs1_tag;
        logic [DATA_W-1:0]    rs1_val;
        logic                 rs2_busy;
        logic [ROB_IDX_W-1:0] rs2_tag;
        logic [DATA_W-1:0]    rs2_val;
        logic [DATA_W-1:0]    imm;
        logic                 committed;
        logic                 reported;
    } entry_t;

    entry_t               entries [DEPTH];
    entry_t               head_e, new_e;
    logic [PTR_W-1:0]     head, tail, commit_sel;
    logic [CNT_W-1:0]     count, committed_cnt;
    state_t               state, state_next;
    logic [ROB_IDX_W-1:0] mem_rob_idx;
    logic                 mem_unsigned;
    logic                 head_ready, head_is_io, head_eligible, advance;
    logic                 do_pop, push, load_done, store_report, commit_hit;
    logic [ADDR_W-1:0]    head_addr;
    logic [DATA_W-1:0]    head_wdata, load_ext;

    // Returns {busy, value} after looking at the CDB; the lowest matching channel wins.
    function automatic logic [DATA_W:0] snoop(input logic busy,
                                              input logic [ROB_IDX_W-1:0] tag,
                                              input logic [DATA_W-1:0] val);
        logic [DATA_W:0] r;
        r = {busy, val};
        if (busy) begin
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_tag[k*ROB_IDX_W +: ROB_IDX_W] == tag)
                    r = {1'b0, cdb_data[k*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    assign head_e        = entries[head];
    assign head_ready    = !head_e.rs1_busy && (!head_e.is_store || !head_e.rs2_busy);
    assign head_addr     = ADDR_W'(head_e.rs1_val + head_e.imm);
    assign head_is_io    = head_addr >= IO_BASE;
    assign head_eligible = (state == IDLE) && (count != '0) && head_ready &&
                           (head_e.is_store ? head_e.committed
                                            : (!head_is_io || rob_head_idx == head_e.rob_idx));
    assign advance       = rdy_in || clr_in;
    assign do_pop        = rdy_in && !clr_in && head_eligible;
    assign push          = rdy_in && !clr_in && issue_valid && !lsq_full;
    assign load_done     = (state == BUSY) && mem_ack && !mem_we;
    assign store_report  = (count != '0) && head_e.is_store && head_ready &&
                           !head_e.reported && !load_done;
    assign lsq_full      = (count == CNT_W'(DEPTH));
    assign lsq_count     = count;

    // Build the incoming entry, capturing any operand broadcast in the same cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        logic [DATA_W:0] s1, s2;
        s1                = snoop(issue_rs1_busy, issue_rs1_tag, issue_rs1_val);
        s2                = snoop(issue_rs2_busy, issue_rs2_tag, issue_rs2_val);
        new_e             = '0;
        new_e.rob_idx     = issue_rob_idx;
        new_e.is_store    = issue_is_store;
        new_e.len         = issue_len;
        new_e.is_unsigned = issue_unsigned;
        new_e.rs1_busy    = s1[DATA_W];
        new_e.rs1_tag     = issue_rs1_tag;
        new_e.rs1_val     = s1[DATA_W-1:0];
        new_e.rs2_busy    = s2[DATA_W];
        new_e.rs2_tag     = issue_rs2_tag;
        new_e.rs2_val     = s2[DATA_W-1:0];
        new_e.imm         = issue_imm;
    end

    // Locate the live, uncommitted entry named by the ROB commit.
    always_comb begin
        logic [PTR_W-1:0] off;
        off        = '0;
        commit_hit = 1'b0;
        commit_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - head;
            if (rob_commit_valid && ({1'b0, off} < count) && !entries[i].committed &&
                entries[i].rob_idx == rob_commit_idx) begin
                commit_hit = 1'b1;
                commit_sel = PTR_W'(i);
            end
        end
    end

    // Store data masked to the access width; load data extended per the held length.
    always_comb begin
        head_wdata = head_e.rs2_val;
        load_ext   = mem_rdata;
        case (head_e.len)
            2'b01:   head_wdata = {{(DATA_W-8){1'b0}}, head_e.rs2_val[7:0]};
            2'b10:   head_wdata = {{(DATA_W-16){1'b0}}, head_e.rs2_val[15:0]};
            default: ;
        endcase
        case (mem_len)
            2'b01:   load_ext = {{(DATA_W-8){~mem_unsigned & mem_rdata[7]}}, mem_rdata[7:0]};
            2'b10:   load_ext = {{(DATA_W-16){~mem_unsigned & mem_rdata[15]}}, mem_rdata[15:0]};
            default: ;
        endcase
    end

    // Memory FSM next state; a flushed outstanding load drains its ack without a result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (do_pop) state_next = BUSY;
            BUSY:    if (mem_ack) state_next = IDLE;
                     else if (clr_in && !mem_we) state_next = DRAIN;
            DRAIN:   if (mem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)    state <= IDLE;
        else if (advance) state <= state_next;
    end

    // Memory request register: loaded on pop, held until ack.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_len      <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_rob_idx  <= '0;
            mem_unsigned <= 1'b0;
        end else if (advance) begin
            if (do_pop) begin
                mem_req      <= 1'b1;
                mem_we       <= head_e.is_store;
                mem_len      <= head_e.len;
                mem_addr     <= head_addr;
                mem_wdata    <= head_wdata;
                mem_rob_idx  <= head_e.rob_idx;
                mem_unsigned <= head_e.is_unsigned;
            end else if (state != IDLE && mem_ack) begin
                mem_req <= 1'b0;
            end
        end
    end

    // Result pulse: load completion takes priority over a store report.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            result_valid   <= 1'b0;
            result_rob_idx <= '0;
            result_data    <= '0;
        end else if (clr_in) begin
            result_valid <= 1'b0;
        end else if (rdy_in) begin
            result_valid <= 1'b0;
            if (load_done) begin
                result_valid   <= 1'b1;
                result_rob_idx <= mem_rob_idx;
                result_data    <= load_ext;
            end else if (store_report) begin
                result_valid   <= 1'b1;
                result_rob_idx <= head_e.rob_idx;
                result_data    <= '0;
            end
        end
    end

    // Queue storage, pointers and counters.
    // NOTE: the entry array is reset so busy/committed/reported flags never start as X.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            entries       <= '{default: '0};
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            committed_cnt <= '0;
        end else if (clr_in) begin
            tail  <= head + committed_cnt[PTR_W-1:0];
            count <= committed_cnt;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                {entries[i].rs1_busy, entries[i].rs1_val} <=
                    snoop(entries[i].rs1_busy, entries[i].rs1_tag, entries[i].rs1_val);
                {entries[i].rs2_busy, entries[i].rs2_val} <=
                    snoop(entries[i].rs2_busy, entries[i].rs2_tag, entries[i].rs2_val);
            end
            if (store_report) entries[head].reported <= 1'b1;
            if (commit_hit) entries[commit_sel].committed <= 1'b1;
            if (push) begin
                entries[tail] <= new_e;
                tail          <= tail + PTR_W'(1);
            end
            if (do_pop) head <= head + PTR_W'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            committed_cnt <= committed_cnt + (commit_hit ? CNT_W'(1) : CNT_W'(0))
                           - ((do_pop && head_e.committed) ? CNT_W'(1) : CNT_W'(0));
        end
    end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: one task per scenario, inline comparisons.
module tb_load_store_queue;
    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, clr_in;
    logic        issue_valid, issue_is_store, issue_unsigned;
    logic [3:0]  issue_rob_idx, issue_rs1_tag, issue_rs2_tag;
    logic [1:0]  issue_len;
    logic        issue_rs1_busy, issue_rs2_busy;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        rob_commit_valid;
    logic [3:0]  rob_commit_idx, rob_head_idx;
    logic        mem_req, mem_we, mem_ack;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        lsq_full;
    logic [3:0]  lsq_count;
    logic        result_valid;
    logic [3:0]  result_rob_idx;
    logic [31:0] result_data;

    int checks   = 0;
    int failures = 0;

    load_store_queue dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .issue_valid(issue_valid), .issue_rob_idx(issue_rob_idx),
        .issue_is_store(issue_is_store), .issue_len(issue_len),
        .issue_unsigned(issue_unsigned), .issue_rs1_busy(issue_rs1_busy),
        .issue_rs1_tag(issue_rs1_tag), .issue_rs1_val(issue_rs1_val),
        .issue_rs2_busy(issue_rs2_busy), .issue_rs2_tag(issue_rs2_tag),
        .issue_rs2_val(issue_rs2_val), .issue_imm(issue_imm),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_commit_valid(rob_commit_valid), .rob_commit_idx(rob_commit_idx),
        .rob_head_idx(rob_head_idx), .mem_req(mem_req), .mem_we(mem_we),
        .mem_len(mem_len), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .lsq_full(lsq_full),
        .lsq_count(lsq_count), .result_valid(result_valid),
        .result_rob_idx(result_rob_idx), .result_data(result_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        clr_in = 1'b0; issue_valid = 1'b0; issue_rob_idx = '0; issue_is_store = 1'b0;
        issue_len = 2'b11; issue_unsigned = 1'b0; issue_rs1_busy = 1'b0; issue_rs1_tag = '0;
        issue_rs1_val = '0; issue_rs2_busy = 1'b0; issue_rs2_tag = '0; issue_rs2_val = '0;
        issue_imm = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        rob_commit_valid = 1'b0; rob_commit_idx = '0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy_in = 1'b1; rob_head_idx = '0; rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        tick();
    endtask

    task automatic issue_load(input logic [3:0] tag, input logic [1:0] len, input logic uns,
                              input logic busy, input logic [3:0] btag,
                              input logic [31:0] rs1, input logic [31:0] imm);
        issue_valid = 1'b1; issue_is_store = 1'b0; issue_rob_idx = tag; issue_len = len;
        issue_unsigned = uns; issue_rs1_busy = busy; issue_rs1_tag = btag;
        issue_rs1_val = rs1; issue_imm = imm; issue_rs2_busy = 1'b0;
    endtask

    task automatic issue_store(input logic [3:0] tag, input logic [31:0] rs1,
                               input logic [31:0] imm, input logic busy2,
                               input logic [3:0] tag2, input logic [31:0] rs2);
        issue_valid = 1'b1; issue_is_store = 1'b1; issue_rob_idx = tag; issue_len = 2'b11;
        issue_unsigned = 1'b0; issue_rs1_busy = 1'b0; issue_rs1_val = rs1; issue_imm = imm;
        issue_rs2_busy = busy2; issue_rs2_tag = tag2; issue_rs2_val = rs2;
    endtask

    // Advances until mem_req is seen or the cycle budget runs out.
    task automatic wait_req(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (mem_req) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    // Runs one ready load at 0x1000 and returns what the result port showed after the ack.
    task automatic run_load(input logic [3:0] tag, input logic [1:0] len, input logic uns,
                            input logic [31:0] rdata, output bit ok,
                            output logic rv, output logic [31:0] rd);
        issue_load(tag, len, uns, 1'b0, 4'd0, 32'h1000, 32'h0);
        tick();
        issue_valid = 1'b0;
        wait_req(10, ok);
        mem_ack = 1'b1; mem_rdata = rdata;
        tick();
        mem_ack = 1'b0;
        rv = result_valid; rd = result_data;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (lsq_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", lsq_count); end
        checks++; if (lsq_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", lsq_full); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_result got=%b exp=0", result_valid); end
    endtask

    task automatic test_load_word();
        do_reset();
        issue_load(4'd1, 2'b11, 1'b0, 1'b0, 4'd0, 32'h100, 32'h4);
        tick();
        issue_valid = 1'b0;
        checks++; if (lsq_count !== 4'd1) begin failures++; $display("FAIL lw_count got=%0d exp=1", lsq_count); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lw_req_early got=%b exp=0", mem_req); end
        tick();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL lw_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h104) begin failures++; $display("FAIL lw_addr got=%h exp=104", mem_addr); end
        checks++; if (mem_len !== 2'b11 || mem_we !== 1'b0) begin failures++; $display("FAIL lw_len_we got=%b/%b exp=11/0", mem_len, mem_we); end
        checks++; if (lsq_count !== 4'd0) begin failures++; $display("FAIL lw_pop_count got=%0d exp=0", lsq_count); end
        mem_ack = 1'b1; mem_rdata = 32'h80;
        tick();
        mem_ack = 1'b0;
        checks++; if (result_valid !== 1'b1 || result_data !== 32'h80 || result_rob_idx !== 4'd1) begin
            failures++; $display("FAIL lw_result got=%b/%h/%0d exp=1/80/1", result_valid, result_data, result_rob_idx); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lw_req_drop got=%b exp=0", mem_req); end
        tick();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL lw_pulse got=%b exp=0", result_valid); end
    endtask

    task automatic test_load_extend();
        bit ok; logic rv; logic [31:0] rd;
        do_reset();
        run_load(4'd2, 2'b01, 1'b0, 32'h123456FF, ok, rv, rd);
        checks++; if (!ok || rv !== 1'b1 || rd !== 32'hFFFFFFFF) begin failures++; $display("FAIL lb got=%b/%b/%h exp=1/1/ffffffff", ok, rv, rd); end
        run_load(4'd3, 2'b01, 1'b1, 32'h000000FF, ok, rv, rd);
        checks++; if (!ok || rv !== 1'b1 || rd !== 32'h000000FF) begin failures++; $display("FAIL lbu got=%b/%b/%h exp=1/1/000000ff", ok, rv, rd); end
        run_load(4'd4, 2'b10, 1'b0, 32'h00008000, ok, rv, rd);
        checks++; if (!ok || rv !== 1'b1 || rd !== 32'hFFFF8000) begin failures++; $display("FAIL lh got=%b/%b/%h exp=1/1/ffff8000", ok, rv, rd); end
        run_load(4'd5, 2'b10, 1'b1, 32'h12348000, ok, rv, rd);
        checks++; if (!ok || rv !== 1'b1 || rd !== 32'h00008000) begin failures++; $display("FAIL lhu got=%b/%b/%h exp=1/1/00008000", ok, rv, rd); end
    endtask

    task automatic test_store_commit();
        do_reset();
        issue_store(4'd3, 32'h40, 32'h0, 1'b1, 4'd5, 32'h0);
        tick();
        issue_valid = 1'b0;
        checks++; if (lsq_count !== 4'd1 || result_valid !== 1'b0) begin failures++; $display("FAIL sw_enq got=%0d/%b exp=1/0", lsq_count, result_valid); end
        cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd7}; cdb_data = {32'hAB, 32'h55};
        tick();
        cdb_valid = '0;
        tick();
        checks++; if (result_valid !== 1'b1 || result_rob_idx !== 4'd3 || result_data !== 32'h0) begin
            failures++; $display("FAIL sw_report got=%b/%0d/%h exp=1/3/0", result_valid, result_rob_idx, result_data); end
        tick();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL sw_report_once got=%b exp=0", result_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sw_wait_commit cyc=%0d got=%b exp=0", i, mem_req); end
        end
        rob_commit_valid = 1'b1; rob_commit_idx = 4'd3;
        tick();
        rob_commit_valid = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL sw_req got=%b/%b exp=1/1", mem_req, mem_we); end
        checks++; if (mem_wdata !== 32'hAB || mem_addr !== 32'h40) begin failures++; $display("FAIL sw_data got=%h/%h exp=ab/40", mem_wdata, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || result_valid !== 1'b0 || lsq_count !== 4'd0) begin
            failures++; $display("FAIL sw_done got=%b/%b/%0d exp=0/0/0", mem_req, result_valid, lsq_count); end
    endtask

    task automatic test_cdb();
        do_reset();
        issue_load(4'd2, 2'b11, 1'b0, 1'b1, 4'd6, 32'h0, 32'h10);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd6}; cdb_data = {32'h0, 32'h300};
        tick();
        issue_valid = 1'b0; cdb_valid = '0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h310) begin failures++; $display("FAIL cdb_same_cycle got=%b/%h exp=1/310", mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        issue_load(4'd4, 2'b11, 1'b0, 1'b1, 4'd9, 32'h0, 32'h0);
        tick();
        issue_valid = 1'b0;
        cdb_valid = 2'b11; cdb_tag = {4'd9, 4'd9}; cdb_data = {32'h700, 32'h500};
        tick();
        cdb_valid = '0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cdb_wait got=%b exp=0", mem_req); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin failures++; $display("FAIL cdb_low_wins got=%b/%h exp=1/500", mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue_load(4'(i), 2'b11, 1'b0, 1'b1, 4'd9, 32'h0, 32'h0);
            tick();
        end
        issue_valid = 1'b0;
        checks++; if (lsq_count !== 4'd8 || lsq_full !== 1'b1) begin failures++; $display("FAIL full got=%0d/%b exp=8/1", lsq_count, lsq_full); end
        issue_load(4'd15, 2'b11, 1'b0, 1'b0, 4'd0, 32'h40, 32'h0);
        tick();
        issue_valid = 1'b0;
        checks++; if (lsq_count !== 4'd8) begin failures++; $display("FAIL full_drop got=%0d exp=8", lsq_count); end
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_data = {32'h0, 32'h100};
        tick();
        cdb_valid = '0;
        tick();
        checks++; if (mem_req !== 1'b1 || lsq_count !== 4'd7 || lsq_full !== 1'b0) begin
            failures++; $display("FAIL full_pop got=%b/%0d/%b exp=1/7/0", mem_req, lsq_count, lsq_full); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        issue_load(4'd14, 2'b11, 1'b0, 1'b0, 4'd0, 32'h80, 32'h0);
        tick();
        issue_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || lsq_count !== 4'd7) begin failures++; $display("FAIL pop_push got=%b/%0d exp=1/7", mem_req, lsq_count); end
        issue_load(4'd13, 2'b11, 1'b0, 1'b0, 4'd0, 32'h80, 32'h0);
        tick();
        issue_valid = 1'b0;
        checks++; if (lsq_count !== 4'd8 || lsq_full !== 1'b1) begin failures++; $display("FAIL refill got=%0d/%b exp=8/1", lsq_count, lsq_full); end
    endtask

    task automatic test_io_load();
        do_reset();
        rob_head_idx = 4'd2;
        issue_load(4'd4, 2'b11, 1'b0, 1'b0, 4'd0, 32'h30000, 32'h0);
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL io_wait cyc=%0d got=%b exp=0", i, mem_req); end
        end
        rob_head_idx = 4'd4;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h30000) begin failures++; $display("FAIL io_go got=%b/%h exp=1/30000", mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        rob_head_idx = 4'd0;
        issue_load(4'd5, 2'b11, 1'b0, 1'b0, 4'd0, 32'h2FFFC, 32'h3);
        tick();
        issue_valid = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2FFFF) begin failures++; $display("FAIL below_io got=%b/%h exp=1/2ffff", mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_rdy();
        do_reset();
        rdy_in = 1'b0;
        issue_load(4'd1, 2'b11, 1'b0, 1'b0, 4'd0, 32'h100, 32'h0);
        tick();
        issue_valid = 1'b0;
        checks++; if (lsq_count !== 4'd0) begin failures++; $display("FAIL rdy_freeze_enq got=%0d exp=0", lsq_count); end
        rdy_in = 1'b1;
        issue_load(4'd1, 2'b11, 1'b0, 1'b0, 4'd0, 32'h100, 32'h0);
        tick();
        issue_valid = 1'b0; rdy_in = 1'b0;
        tick(); tick();
        checks++; if (mem_req !== 1'b0 || lsq_count !== 4'd1) begin failures++; $display("FAIL rdy_freeze_pop got=%b/%0d exp=0/1", mem_req, lsq_count); end
        rdy_in = 1'b1;
        tick();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rdy_resume got=%b exp=1", mem_req); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        issue_load(4'd1, 2'b11, 1'b0, 1'b0, 4'd0, 32'h100, 32'h0);
        tick();
        issue_store(4'd2, 32'h200, 32'h0, 1'b0, 4'd0, 32'h77);
        tick();
        issue_load(4'd3, 2'b11, 1'b0, 1'b0, 4'd0, 32'h300, 32'h0);
        tick();
        issue_valid = 1'b0;
        rob_commit_valid = 1'b1; rob_commit_idx = 4'd2;
        tick();
        rob_commit_valid = 1'b0;
        checks++; if (lsq_count !== 4'd2 || mem_req !== 1'b1 || mem_we !== 1'b0) begin
            failures++; $display("FAIL fl_pre got=%0d/%b/%b exp=2/1/0", lsq_count, mem_req, mem_we); end
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        checks++; if (lsq_count !== 4'd1 || mem_req !== 1'b1 || result_valid !== 1'b0) begin
            failures++; $display("FAIL fl_clr got=%0d/%b/%b exp=1/1/0", lsq_count, mem_req, result_valid); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD;
        tick();
        mem_ack = 1'b0;
        checks++; if (result_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL fl_drain got=%b/%b exp=0/0", result_valid, mem_req); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h77) begin
            failures++; $display("FAIL fl_store got=%b/%b/%h/%h exp=1/1/200/77", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if (lsq_count !== 4'd0) begin failures++; $display("FAIL fl_empty got=%0d exp=0", lsq_count); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store_commit();
        test_cdb();
        test_full();
        test_io_load();
        test_rdy();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
